// File: rtl/texture_fetch_requester.sv
// Texture read initiator: splits fetch commands into PSRAM read bursts and streams the
// returned words to the texture unit, reserving read-FIFO room with credits before each burst.
module texture_fetch_requester #(
   parameter int MAX_BURST    = 63,
   parameter int RDFIFO_DEPTH = 512
) (
   input  logic        clk75,
   input  logic        rst,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [22:0] cmd_addr,
   input  logic [15:0] cmd_words,
   output logic [31:0] TextureReadReq_WriteData,
   output logic        TextureReadReq_push,
   input  logic        TextureReadReq_full,
   input  logic [31:0] TextureReadFIFO_ReadData,
   output logic        TextureReadFIFO_pop,
   input  logic        TextureReadFIFO_empty,
   output logic [31:0] out_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        out_last,
   output logic        busy
);

   localparam int            CW           = $clog2(RDFIFO_DEPTH + 1);
   localparam logic [CW-1:0] CREDITS_FULL = CW'(RDFIFO_DEPTH);
   localparam logic [15:0]   MAX_BURST_W  = 16'(MAX_BURST);
   localparam logic [5:0]    MAX_BURST_C  = 6'(MAX_BURST);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t        state_q;
   logic [22:0]   addr_q;
   logic [15:0]   iss_rem_q;
   logic [15:0]   dlv_rem_q;
   logic [15:0]   ld_rem_q;
   logic [CW-1:0] credits_q;
   logic [CW-1:0] credits_d;
   logic [31:0]   wdata_q;
   logic [31:0]   out_data_q;
   logic          push_q;
   logic          out_valid_q;
   logic          out_last_q;

   logic [5:0]    chunk;
   logic [31:0]   req_word;
   logic [15:0]   credits_n;
   logic          issue_go;
   logic          pop;
   logic          out_hs;

   // NOTE: push is registered, so the full flag cannot yet reflect a push still on the
   // wire; a new burst is only decided while no push is outstanding.
   always_comb begin
      chunk     = (iss_rem_q < MAX_BURST_W) ? iss_rem_q[5:0] : MAX_BURST_C;
      req_word  = {1'b0, chunk, 1'b0, 1'b0, addr_q};
      issue_go  = (state_q == ISSUE) && !push_q && !TextureReadReq_full &&
                  (16'(credits_q) >= 16'(chunk));
      pop       = (state_q != IDLE) && !TextureReadFIFO_empty && (ld_rem_q != 16'd0) &&
                  (!out_valid_q || out_ready);
      out_hs    = out_valid_q && out_ready;
      credits_n = 16'(credits_q) - (issue_go ? 16'(chunk) : 16'd0) + (pop ? 16'd1 : 16'd0);
      credits_d = (credits_n > 16'(RDFIFO_DEPTH)) ? CREDITS_FULL : credits_n[CW-1:0];
   end

   always_ff @(posedge clk75 or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         iss_rem_q   <= '0;
         dlv_rem_q   <= '0;
         ld_rem_q    <= '0;
         credits_q   <= CREDITS_FULL;
         wdata_q     <= '0;
         out_data_q  <= '0;
         push_q      <= 1'b0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         push_q    <= 1'b0;
         credits_q <= credits_d;

         // Output register: refilled on pop, emptied by a handshake with no refill.
         if (pop) begin
            out_data_q  <= TextureReadFIFO_ReadData;
            out_valid_q <= 1'b1;
            out_last_q  <= (ld_rem_q == 16'd1);
            ld_rem_q    <= ld_rem_q - 16'd1;
         end else if (out_hs) begin
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
         end
         if (out_hs) begin
            dlv_rem_q <= dlv_rem_q - 16'd1;
         end

         case (state_q)
            IDLE: begin
               if (cmd_valid && (cmd_words != 16'd0)) begin
                  addr_q    <= cmd_addr;
                  iss_rem_q <= cmd_words;
                  dlv_rem_q <= cmd_words;
                  ld_rem_q  <= cmd_words;
                  state_q   <= ISSUE;
               end
            end
            ISSUE: begin
               if (issue_go) begin
                  push_q    <= 1'b1;
                  wdata_q   <= req_word;
                  addr_q    <= addr_q + {16'd0, chunk, 1'b0};
                  iss_rem_q <= iss_rem_q - 16'(chunk);
                  if (iss_rem_q == 16'(chunk)) begin
                     state_q <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (out_hs && (dlv_rem_q == 16'd1)) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign cmd_ready                = (state_q == IDLE);
   assign busy                     = (state_q != IDLE);
   assign TextureReadReq_WriteData = wdata_q;
   assign TextureReadReq_push      = push_q;
   assign TextureReadFIFO_pop      = pop;
   assign out_data                 = out_data_q;
   assign out_valid                = out_valid_q;
   assign out_last                 = out_last_q;

endmodule

// File: tb/tb_texture_fetch_requester.sv
// Bench for texture_fetch_requester: FIFO/controller environment, burst-splitting reference
// model, table-driven commands, hand-written corner sequences and randomized commands.
module tb_texture_fetch_requester;

   localparam int MAX_BURST = 63;
   localparam int DEPTH     = 64;
   localparam int BUDGET    = 5000;

   logic        clk75 = 1'b0;
   logic        rst;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [22:0] cmd_addr;
   logic [15:0] cmd_words;
   logic [31:0] wdata;
   logic        push;
   logic        req_full = 1'b0;
   logic [31:0] rd_data = 32'h0;
   logic        pop;
   logic        rd_empty = 1'b1;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        out_last;
   logic        busy;

   always #5 clk75 = ~clk75;

   texture_fetch_requester #(.MAX_BURST(MAX_BURST), .RDFIFO_DEPTH(DEPTH)) dut (
      .clk75                    (clk75),
      .rst                      (rst),
      .cmd_valid                (cmd_valid),
      .cmd_ready                (cmd_ready),
      .cmd_addr                 (cmd_addr),
      .cmd_words                (cmd_words),
      .TextureReadReq_WriteData (wdata),
      .TextureReadReq_push      (push),
      .TextureReadReq_full      (req_full),
      .TextureReadFIFO_ReadData (rd_data),
      .TextureReadFIFO_pop      (pop),
      .TextureReadFIFO_empty    (rd_empty),
      .out_data                 (out_data),
      .out_valid                (out_valid),
      .out_ready                (out_ready),
      .out_last                 (out_last),
      .busy                     (busy)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // Environment state: ready/full modes 0=low, 1=high, 2=random.
   int          ready_mode = 0;
   int          full_mode  = 0;
   bit          gen_fast   = 1'b1;
   logic [31:0] rd_q[$];
   logic [31:0] exp_data[$];
   logic [31:0] got_req[$];
   logic [31:0] exp_req[$];
   int          pops_at_push[$];
   int          pend      = 0;
   int          pops_cnt  = 0;
   int          delivered = 0;
   int          last_seen = 0;
   int          cur_words = 0;
   logic [31:0] d;

   // Request FIFO, PSRAM controller and read FIFO, plus the output scoreboard.
   always @(posedge clk75 or posedge rst) begin
      if (rst) begin
         rd_q.delete();
         exp_data.delete();
         pend = 0;
         rd_empty  <= 1'b1;
         rd_data   <= 32'h0;
         req_full  <= 1'b0;
         out_ready <= 1'b0;
      end else begin
         if (pop) begin
            check("pop_nonempty", 32'(rd_q.size() != 0), 32'd1);
            if (rd_q.size() != 0) void'(rd_q.pop_front());
            pops_cnt++;
         end
         if (out_valid && out_ready) begin
            delivered++;
            check("out_expected", 32'(exp_data.size() != 0), 32'd1);
            if (exp_data.size() != 0) check("out_data", out_data, exp_data.pop_front());
            check("out_last", 32'(out_last), 32'(delivered == cur_words));
            if (out_last) last_seen++;
         end
         if (push) begin
            check("push_not_full", 32'(req_full), 32'd0);
            got_req.push_back(wdata);
            pops_at_push.push_back(pops_cnt);
            pend += int'(wdata[30:25]);
         end
         if (pend > 0 && (gen_fast || $urandom_range(0, 2) != 0)) begin
            d = $urandom;
            rd_q.push_back(d);
            exp_data.push_back(d);
            pend--;
            check("rdfifo_room", 32'(rd_q.size() <= DEPTH), 32'd1);
         end
         rd_empty <= (rd_q.size() == 0);
         rd_data  <= (rd_q.size() != 0) ? rd_q[0] : 32'h0;
         case (ready_mode)
            0:       out_ready <= 1'b0;
            1:       out_ready <= 1'b1;
            default: out_ready <= 1'($urandom_range(0, 1));
         endcase
         // A real request FIFO only becomes full as a result of a push.
         case (full_mode)
            0:       req_full <= 1'b0;
            1:       req_full <= 1'b1;
            default: req_full <= req_full ? ($urandom_range(0, 2) != 0)
                                          : (push && ($urandom_range(0, 1) == 0));
         endcase
      end
   end

   // Reference: the request words a command must produce, straight from the word format.
   task automatic build_expected(input logic [22:0] a, input int w);
      int rem;
      int c;
      int ad;
      rem = w;
      ad  = int'(a);
      exp_req.delete();
      while (rem > 0) begin
         c = (rem < MAX_BURST) ? rem : MAX_BURST;
         exp_req.push_back({1'b0, 7'(2 * c), 1'b0, 23'(ad)});
         ad  = (ad + 2 * c) % (1 << 23);
         rem = rem - c;
      end
   endtask

   task automatic start_cmd(input logic [22:0] a, input logic [15:0] w, input int rmode,
                            input int fmode);
      @(negedge clk75);
      ready_mode = rmode;
      full_mode  = fmode;
      got_req.delete();
      pops_at_push.delete();
      delivered = 0;
      last_seen = 0;
      pops_cnt  = 0;
      cur_words = int'(w);
      build_expected(a, int'(w));
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_words = w;
      @(negedge clk75);
      cmd_valid = 1'b0;
   endtask

   task automatic finish_cmd();
      int cyc;
      cyc = 0;
      while ((busy || delivered != cur_words) && cyc < BUDGET) begin
         @(negedge clk75);
         cyc++;
      end
      check("done_in_time", 32'(cyc < BUDGET), 32'd1);
      if (cur_words == 0) repeat (5) @(negedge clk75);
      check("n_push", got_req.size(), exp_req.size());
      for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
         check("req_word", got_req[i], exp_req[i]);
      check("n_out", delivered, cur_words);
      check("n_last", last_seen, 32'(cur_words != 0));
      check("no_leftover", 32'(exp_data.size() + rd_q.size()), 32'd0);
      check("idle_after", 32'(cmd_ready && !busy), 32'd1);
   endtask

   task automatic run_cmd(input logic [22:0] a, input logic [15:0] w, input int rmode,
                          input int fmode);
      start_cmd(a, w, rmode, fmode);
      finish_cmd();
   endtask

   typedef struct {
      logic [22:0] addr;
      logic [15:0] words;
      int          rmode;
      int          fmode;
      int          n_push;
      logic [31:0] first_req;
      logic [31:0] last_req;
   } vec_t;

   vec_t        vecs[6];
   logic [22:0] ra;
   int          rw;
   int          cyc;

   initial begin
      vecs[0] = '{23'h000100, 16'd4,   1, 0, 1, 32'h08000100, 32'h08000100};
      vecs[1] = '{23'h000000, 16'd130, 1, 0, 3, 32'h7E000000, 32'h080000FC};
      vecs[2] = '{23'h7FFFFC, 16'd70,  1, 0, 2, 32'h7E7FFFFC, 32'h0E00007A};
      vecs[3] = '{23'h000001, 16'd64,  2, 2, 2, 32'h7E000001, 32'h0200007F};
      vecs[4] = '{23'h7FFFFF, 16'd1,   2, 0, 1, 32'h027FFFFF, 32'h027FFFFF};
      vecs[5] = '{23'h123456, 16'd0,   1, 0, 0, 32'h0,        32'h0};

      rst       = 1'b1;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_words = '0;
      repeat (3) @(negedge clk75);
      check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("rst_push", 32'(push), 32'd0);
      check("rst_pop", 32'(pop), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_last", 32'(out_last), 32'd0);
      check("rst_out_data", out_data, 32'd0);
      check("rst_wdata", wdata, 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_credits", 32'(dut.credits_q), DEPTH);
      rst = 1'b0;

      foreach (vecs[i]) begin
         run_cmd(vecs[i].addr, vecs[i].words, vecs[i].rmode, vecs[i].fmode);
         check("vec_n_push", got_req.size(), vecs[i].n_push);
         if (got_req.size() != 0) begin
            check("vec_first_req", got_req[0], vecs[i].first_req);
            check("vec_last_req", got_req[got_req.size() - 1], vecs[i].last_req);
         end
      end

      // Credits: with the consumer stalled only one burst fits, the second waits for returns.
      start_cmd(23'h000000, 16'd126, 0, 0);
      repeat (100) @(negedge clk75);
      check("credit_hold_pushes", got_req.size(), 1);
      check("credit_hold_valid", 32'(out_valid), 32'd1);
      check("credit_hold_pops", pops_cnt, 1);
      check("credit_hold_credits", 32'(dut.credits_q), 32'd2);
      ready_mode = 1;
      finish_cmd();
      if (pops_at_push.size() > 1)
         check("credit_second_push_pops", 32'(pops_at_push[1] >= 62), 32'd1);

      // Request FIFO full for 10 cycles in ISSUE, then released.
      @(negedge clk75);
      full_mode = 1;
      @(negedge clk75);
      start_cmd(23'h000200, 16'd4, 1, 1);
      repeat (10) begin
         check("full_no_push", 32'(push), 32'd0);
         @(negedge clk75);
      end
      full_mode = 0;
      @(negedge clk75);
      check("full_dropped", 32'(req_full), 32'd0);
      check("full_push_not_yet", 32'(push), 32'd0);
      @(negedge clk75);
      check("full_push_fires", 32'(push), 32'd1);
      check("full_push_word", wdata, 32'h08000200);
      finish_cmd();

      // Asynchronous reset while a word is held in the output register during DRAIN.
      start_cmd(23'h000040, 16'd4, 0, 0);
      cyc = 0;
      while (!out_valid && cyc < 100) begin
         @(negedge clk75);
         cyc++;
      end
      check("pre_rst_valid", 32'(out_valid && busy), 32'd1);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_busy", 32'(busy), 32'd0);
      check("arst_cmd_ready", 32'(cmd_ready), 32'd1);
      check("arst_credits", 32'(dut.credits_q), DEPTH);
      @(negedge clk75);
      rst = 1'b0;
      run_cmd(23'h000055, 16'd0, 1, 0);

      for (int k = 0; k < 20; k++) begin
         ra       = 23'($urandom);
         rw       = $urandom_range(0, 200);
         gen_fast = 1'($urandom_range(0, 1));
         run_cmd(ra, 16'(rw), 2, 2);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
